telem_frame_rx: RTL and testbench

- Receive-end deframer for the temperature telemetry link. It sits after uArtRx, which delivers one byte plus a one-cycle strobe per received character.
- It assembles 8-byte telemetry frames (header, temperature, timestamp fields, checksum) and validates them.
- Each good frame produces one record-valid pulse with the decoded temperature and timestamp, plus an over-temperature flag.
- It is the decoder counterpart of the pipe-side framer that serialises temp and digiClock time through uArtTx.

---
 rtl/telem_frame_rx.sv | 131 +++++++++++++
 tb/tb_telem_frame_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/telem_frame_rx.sv
// rtl/telem_frame_rx.sv - telemetry frame deframer: assembles and validates 8-byte frames from the UART receiver
module telem_frame_rx #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
  parameter logic [7:0]  ALARM_TEMP     = 8'd90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] rec_temp,
  output logic [5:0] rec_seconds,
  output logic [5:0] rec_minuits,
  output logic [4:0] rec_hours,
  output logic [4:0] rec_days,
  output logic [3:0] rec_months,
  output logic       rec_valid,
  output logic       rec_alarm,
  output logic       frame_err,
  output logic [7:0] frame_count,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx;
  logic [6:1][7:0]  shadow;
  logic [7:0]       xor_acc;
  logic [7:0]       chk_rx;
  logic [19:0]      tmo_cnt;
  logic             timeout;
  logic             reserved_ok;
  logic             frame_good;
  logic             rec_load;
  logic             err_fire;

  // A byte arriving in the same cycle as the limit always wins over the timeout.
  assign timeout     = (state == COLLECT) && !rx_valid && (tmo_cnt == TIMEOUT_CYCLES);
  assign reserved_ok = ~|{shadow[2][7:6], shadow[3][7:6], shadow[4][7:5],
                          shadow[5][7:5], shadow[6][7:4]};
  assign frame_good  = (chk_rx == xor_acc) && reserved_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_valid && rx_data == HEADER) state_nxt = COLLECT;
      COLLECT: begin
        if (rx_valid && idx == 3'd7) state_nxt = CHECK;
        else if (timeout)            state_nxt = IDLE;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rec_load = 1'b0;
    err_fire = 1'b0;
    if (state == CHECK) begin
      rec_load = frame_good;
      err_fire = !frame_good;
    end
    if (timeout) err_fire = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      shadow      <= '0;
      xor_acc     <= '0;
      chk_rx      <= '0;
      tmo_cnt     <= '0;
      rec_temp    <= '0;
      rec_seconds <= '0;
      rec_minuits <= '0;
      rec_hours   <= '0;
      rec_days    <= '0;
      rec_months  <= '0;
      rec_valid   <= 1'b0;
      rec_alarm   <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      rec_valid <= 1'b0;
      frame_err <= 1'b0;
      if (state == COLLECT && !rx_valid) tmo_cnt <= tmo_cnt + 20'd1;
      else                               tmo_cnt <= '0;

      case (state)
        IDLE: if (rx_valid && rx_data == HEADER) begin
          idx     <= 3'd1;
          xor_acc <= '0;
        end
        COLLECT: if (rx_valid) begin
          if (idx == 3'd7) begin
            chk_rx <= rx_data;
          end else begin
            shadow[idx] <= rx_data;
            xor_acc     <= xor_acc ^ rx_data;
          end
          idx <= idx + 3'd1;
        end
        default: ;
      endcase

      if (rec_load) begin
        rec_temp    <= shadow[1];
        rec_seconds <= shadow[2][5:0];
        rec_minuits <= shadow[3][5:0];
        rec_hours   <= shadow[4][4:0];
        rec_days    <= shadow[5][4:0];
        rec_months  <= shadow[6][3:0];
        rec_alarm   <= (shadow[1] >= ALARM_TEMP);
        rec_valid   <= 1'b1;
        if (frame_count != 8'hFF) frame_count <= frame_count + 8'd1;
      end
      if (err_fire) begin
        frame_err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_telem_frame_rx.sv
// tb/tb_telem_frame_rx.sv - self-checking bench for telem_frame_rx
module tb_telem_frame_rx;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rec_temp;
  logic [5:0] rec_seconds, rec_minuits;
  logic [4:0] rec_hours, rec_days;
  logic [3:0] rec_months;
  logic       rec_valid, rec_alarm, frame_err;
  logic [7:0] frame_count, err_count;

  telem_frame_rx #(.HEADER(8'hA5), .TIMEOUT_CYCLES(20'(TMO)), .ALARM_TEMP(8'd90)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rec_temp(rec_temp), .rec_seconds(rec_seconds), .rec_minuits(rec_minuits),
    .rec_hours(rec_hours), .rec_days(rec_days), .rec_months(rec_months),
    .rec_valid(rec_valid), .rec_alarm(rec_alarm), .frame_err(frame_err),
    .frame_count(frame_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] bytes;
    logic        good;
    logic [7:0]  temp;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hr;
    logic [4:0]  day;
    logic [3:0]  mon;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [7:0] temp;
    logic [5:0] sec, min;
    logic [4:0] hr, day;
    logic [3:0] mon;
    logic       alarm;
    logic [7:0] fc, ec;
    int         lo, hi;
  } exp_t;

  exp_t q[$];
  exp_t m;
  exp_t mon_e;
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m = '{default: '0};
  endtask

  task automatic expect_frame(input logic good, input vec_t v, input int lo, input int hi);
    exp_t e;
    if (good) begin
      m.temp = v.temp; m.sec = v.sec; m.min = v.min;
      m.hr = v.hr; m.day = v.day; m.mon = v.mon;
      m.alarm = (v.temp >= 8'd90);
      if (m.fc != 8'hFF) m.fc = m.fc + 8'd1;
    end else if (m.ec != 8'hFF) begin
      m.ec = m.ec + 8'd1;
    end
    e = m;
    e.is_err = !good;
    e.lo = lo;
    e.hi = hi;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, output int n);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
    end
  endtask

  // long_gap inserts that many idle cycles after byte 3 to stress the inter-byte timer
  task automatic send_frame(input vec_t v, input int maxgap, input int long_gap, input int tail);
    int n;
    for (int i = 0; i < 8; i++) begin
      send_byte(v.bytes[63-8*i -: 8], n);
      if (i == 3 && long_gap > 0) idle(long_gap);
      else if (i < 7) idle($urandom_range(0, maxgap));
    end
    expect_frame(v.good, v, n + 1, n + 1);
    idle(tail);
  endtask

  task automatic check_zero();
    check("rst_temp", rec_temp, 0);
    check("rst_sec", rec_seconds, 0);
    check("rst_min", rec_minuits, 0);
    check("rst_hr", rec_hours, 0);
    check("rst_day", rec_days, 0);
    check("rst_mon", rec_months, 0);
    check("rst_valid", rec_valid, 0);
    check("rst_alarm", rec_alarm, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_fcount", frame_count, 0);
    check("rst_ecount", err_count, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset && (rec_valid || frame_err)) begin
      if (q.size() == 0) begin
        check("spurious_event", {30'd0, rec_valid, frame_err}, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("frame_err", frame_err, mon_e.is_err);
        check("rec_valid", rec_valid, !mon_e.is_err);
        check("rec_temp", rec_temp, mon_e.temp);
        check("rec_seconds", rec_seconds, mon_e.sec);
        check("rec_minuits", rec_minuits, mon_e.min);
        check("rec_hours", rec_hours, mon_e.hr);
        check("rec_days", rec_days, mon_e.day);
        check("rec_months", rec_months, mon_e.mon);
        check("rec_alarm", rec_alarm, mon_e.alarm);
        check("frame_count", frame_count, mon_e.fc);
        check("err_count", err_count, mon_e.ec);
        n_checks++;
        if (cyc >= mon_e.lo && cyc <= mon_e.hi) n_pass++;
        else $display("FAIL event_cycle: got %0d expected %0d..%0d", cyc, mon_e.lo, mon_e.hi);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{64'hA53C1E2D0C0F060A, 1'b1, 8'h3C, 6'd30, 6'd45, 5'd12, 5'd15, 4'd6};
    vecs[1] = '{64'hA55A00000001015A, 1'b1, 8'd90, 6'd0, 6'd0, 5'd0, 5'd1, 4'd1};
    vecs[2] = '{64'hA559000000010159, 1'b1, 8'h59, 6'd0, 6'd0, 5'd0, 5'd1, 4'd1};
    vecs[3] = '{64'hA53C1E2D0C0F060B, 1'b0, 8'h0, 6'd0, 6'd0, 5'd0, 5'd0, 4'd0};
    vecs[4] = '{64'hA53C5E2D0C0F064A, 1'b0, 8'h0, 6'd0, 6'd0, 5'd0, 5'd0, 4'd0};
    vecs[5] = '{64'hA5FF3B3B171F0CFB, 1'b1, 8'hFF, 6'd59, 6'd59, 5'd23, 5'd31, 4'd12};
    vecs[6] = '{64'hA5A500000000A5A5, 1'b0, 8'h0, 6'd0, 6'd0, 5'd0, 5'd0, 4'd0};
    // header value as payload: A5 ^ 0 ^ 0 ^ 0 ^ 0 ^ 0 = A5 is a valid checksum
    vecs[6] = '{64'hA5A50000000000A5, 1'b1, 8'hA5, 6'd0, 6'd0, 5'd0, 5'd0, 4'd0};

    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    reset = 1'b1;
    idle(2);

    for (int i = 0; i < 7; i++) send_frame(vecs[i], 2, 0, 3);
    drain();

    // garbage in IDLE is dropped silently
    send_byte(8'h00, n); idle(1);
    send_byte(8'hFF, n);
    send_byte(8'h12, n); idle(2);
    send_frame(vecs[0], 1, 0, 3);
    drain();

    // a header arriving in the CHECK cycle must be ignored
    send_frame(vecs[1], 0, 0, 0);
    send_byte(8'hA5, n);
    idle(TMO + 10);
    drain();

    // inter-byte timeout, then recovery with a near-limit gap
    send_byte(8'hA5, n);
    send_byte(8'h3C, n);
    expect_frame(1'b0, vecs[3], n + TMO - 1, n + TMO + 2);
    idle(TMO + 10);
    drain();
    send_frame(vecs[0], 0, TMO - 5, 3);
    drain();

    // reset in the middle of a frame
    for (int i = 0; i < 4; i++) send_byte(vecs[0].bytes[63-8*i -: 8], n);
    reset = 1'b0;
    #2;
    check_zero();
    model_reset();
    q.delete();
    idle(2);
    reset = 1'b1;
    for (int i = 4; i < 8; i++) begin
      send_byte(vecs[0].bytes[63-8*i -: 8], n);
      idle(1);
    end
    idle(TMO + 5);
    check("post_reset_ecount", err_count, 0);
    check("post_reset_fcount", frame_count, 0);

    // frame_count saturation
    for (int i = 0; i < 256; i++) send_frame(vecs[2], 0, 0, 2);
    drain();
    check("fcount_saturated", frame_count, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
